div_unit: RTL and testbench
===========================

// Module: div_unit
// PURPOSE
//  Iterative radix-2 divider for the RV32M DIV/DIVU/REM/REMU instructions, the inverse of the ALU's
//  single-cycle MUL path. Sits beside the ALU in the execute stage. Controller pulses start with
//  operands; unit computes over multiple cycles; ready/done handshake stalls the core until result.
// PARAMETERS
//  XLEN    32   operand/result width (>=8, power of 2)
//  CNT_W   $clog2(XLEN)  iteration counter width (derived, not overridden)
// PORTS
//  clk      in   1     clock, all state on rising edge
//  rst      in   1     asynchronous, active-high reset
//  start    in   1     request; accepted on rising edge when ready=1
//  divop    in   2     00 DIV, 01 DIVU, 10 REM, 11 REMU; sampled at accept
//  opr_a    in   XLEN  dividend; sampled at accept
//  opr_b    in   XLEN  divisor; sampled at accept
//  abort    in   1     synchronous cancel (pipeline flush)
//  ready    out  1     1 in IDLE only; combinational from state
//  done     out  1     registered; one-cycle pulse, opr_res valid that cycle
//  opr_res  out  XLEN  registered result; held until next done
// BEHAVIOUR
//  Reset (async): state=IDLE, done=0, opr_res=0, counter=0, internal regs=0; ready=1 after reset.
//  States: IDLE, CALC, DONE.
//  IDLE: accept edge E0 when start&ready. Operands, divop latched. Special cases resolved at E0:
//   - opr_b==0: quotient=all ones, remainder=opr_a (signed and unsigned).
//   - DIV/REM with opr_a=2^(XLEN-1), opr_b=all ones: quotient=opr_a, remainder=0.
//   Special: opr_res and done written at E0, state stays IDLE (done high in cycle after E0).
//   Else: signed ops take |opr_a|,|opr_b|, record sign_q=a[MSB]^b[MSB], sign_r=a[MSB];
//   unsigned ops use raw values; state->CALC, counter=0.
//  CALC: one restoring step per edge E1..E_XLEN: shift {rem,quo} left 1, trial-subtract divisor
//   from rem, keep difference and set quo LSB=1 if no borrow, else restore, LSB=0.
//   Counter increments; at counter==XLEN-1 state->DONE.
//  DONE: at edge E_XLEN+1: opr_res=quotient (DIV/DIVU) or remainder (REM/REMU), negated (two's
//   complement, mod 2^XLEN) per sign_q/sign_r for signed ops; done=1; state->IDLE.
//  Latency: normal XLEN+1 cycles accept->done (33 @XLEN=32); special cases 1 cycle.
//  done deasserts the next edge unless a new special-case result is produced on it.
//  ready=1 during the done cycle: back-to-back start accepted, no bubble.
//  start while ready=0: ignored, no queueing; operands changing mid-op have no effect.
//  abort: in CALC/DONE -> IDLE next edge, done stays 0, opr_res unchanged. In IDLE abort wins over
//   start (no accept). abort while done=1 does not retract the pulse already issued.
//  Async reset mid-operation: immediate return to reset values; no done issued.
//  Invalid divop impossible (2-bit fully decoded).
// TESTING
//  1 DIVU 100/7 -> done exactly 33 cycles after accept, opr_res=14; REMU same operands -> 2.
//  2 DIV 0xFFFFFFF9/2 (-7/2) -> 0xFFFFFFFD (-3); REM -> 0xFFFFFFFF (-1); REM 7/-2 -> 1.
//  3 DIVU 5/0 -> 0xFFFFFFFF, done 1 cycle after accept; REM 5/0 -> 5; DIV 0x80000000/
//    0xFFFFFFFF -> 0x80000000, REM -> 0; ready stays 1 throughout.
//  4 start pulsed every cycle during CALC with different operands -> ignored, first result
//    intact; start in done cycle -> second op accepted, its done 33 cycles later.
//  5 abort at cycle 10 of CALC -> IDLE next edge, no done, opr_res holds previous value; abort+
//    start same IDLE edge -> no accept.
//  6 rst asserted mid-CALC between edges -> done=0, opr_res=0, ready=1 immediately; random
//    32-bit operand sweep vs reference model for all four divop values.

Source files
------------

// File: rtl/div_unit_if.sv
// Request/response bundle between the execute-stage controller (master) and
// the iterative divider (slave).
interface div_unit_if #(
  parameter int XLEN = 32
) ();
  logic            start;
  logic [1:0]      divop;
  logic [XLEN-1:0] opr_a;
  logic [XLEN-1:0] opr_b;
  logic            abort;
  logic            ready;
  logic            done;
  logic [XLEN-1:0] opr_res;

  modport master (
    output start, divop, opr_a, opr_b, abort,
    input  ready, done, opr_res
  );

  modport slave (
    input  start, divop, opr_a, opr_b, abort,
    output ready, done, opr_res
  );
endinterface

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Divide-by-zero and signed overflow resolve on the accept edge without iterating.
module div_unit #(
  parameter  int XLEN  = 32,
  localparam int CNT_W = $clog2(XLEN)
) (
  input  logic     clk,
  input  logic     rst,
  div_unit_if.slave bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [CNT_W-1:0] CNT_ONE  = 1;
  localparam logic [CNT_W-1:0] CNT_LAST = XLEN - 1;
  localparam logic [XLEN-1:0]  ALL_ONE  = {XLEN{1'b1}};
  localparam logic [XLEN-1:0]  ALL_ZERO = {XLEN{1'b0}};
  localparam logic [XLEN-1:0]  INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

  function automatic logic [XLEN-1:0] twos_neg(input logic [XLEN-1:0] v);
    return ~v + {{(XLEN-1){1'b0}}, 1'b1};
  endfunction

  logic [1:0]       state_q, state_d;
  logic [XLEN-1:0]  rem_q, rem_d;
  logic [XLEN-1:0]  quo_q, quo_d;
  logic [XLEN-1:0]  dvs_q, dvs_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       op_q, op_d;
  logic             neg_q_q, neg_q_d;
  logic             neg_r_q, neg_r_d;
  logic             done_q, done_d;
  logic [XLEN-1:0]  res_q, res_d;

  logic [XLEN:0]    rem_sh_s;
  logic [XLEN:0]    diff_s;
  logic             is_signed_s;
  logic             b_zero_s;
  logic             ovf_s;

  assign bus.ready   = (state_q == S_IDLE);
  assign bus.done    = done_q;
  assign bus.opr_res = res_q;

  assign is_signed_s = ~bus.divop[0];
  assign b_zero_s    = (bus.opr_b == ALL_ZERO);
  assign ovf_s       = is_signed_s && (bus.opr_a == INT_MIN) && (bus.opr_b == ALL_ONE);

  // One restoring step: shift {rem,quo} left, trial-subtract; diff MSB is the borrow.
  assign rem_sh_s = {rem_q, quo_q[XLEN-1]};
  assign diff_s   = rem_sh_s - {1'b0, dvs_q};

  // Next-state and datapath control
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    neg_q_d = neg_q_q;
    neg_r_d = neg_r_q;
    done_d  = 1'b0;
    res_d   = res_q;
    case (state_q)
      S_IDLE: begin
        if (bus.abort) begin
          state_d = S_IDLE;
        end else if (bus.start) begin
          op_d = bus.divop;
          if (b_zero_s) begin
            done_d = 1'b1;
            res_d  = bus.divop[1] ? bus.opr_a : ALL_ONE;
          end else if (ovf_s) begin
            done_d = 1'b1;
            res_d  = bus.divop[1] ? ALL_ZERO : bus.opr_a;
          end else begin
            if (is_signed_s) begin
              quo_d   = bus.opr_a[XLEN-1] ? twos_neg(bus.opr_a) : bus.opr_a;
              dvs_d   = bus.opr_b[XLEN-1] ? twos_neg(bus.opr_b) : bus.opr_b;
              neg_q_d = bus.opr_a[XLEN-1] ^ bus.opr_b[XLEN-1];
              neg_r_d = bus.opr_a[XLEN-1];
            end else begin
              quo_d   = bus.opr_a;
              dvs_d   = bus.opr_b;
              neg_q_d = 1'b0;
              neg_r_d = 1'b0;
            end
            rem_d   = ALL_ZERO;
            cnt_d   = {CNT_W{1'b0}};
            state_d = S_CALC;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CALC: begin
        if (bus.abort) begin
          state_d = S_IDLE;
        end else begin
          if (diff_s[XLEN]) begin
            rem_d = rem_sh_s[XLEN-1:0];
            quo_d = {quo_q[XLEN-2:0], 1'b0};
          end else begin
            rem_d = diff_s[XLEN-1:0];
            quo_d = {quo_q[XLEN-2:0], 1'b1};
          end
          cnt_d = cnt_q + CNT_ONE;
          if (cnt_q == CNT_LAST) begin
            state_d = S_DONE;
          end else begin
            state_d = S_CALC;
          end
        end
      end
      S_DONE: begin
        if (bus.abort) begin
          state_d = S_IDLE;
        end else begin
          if (op_q[1]) begin
            res_d = neg_r_q ? twos_neg(rem_q) : rem_q;
          end else begin
            res_d = neg_q_q ? twos_neg(quo_q) : quo_q;
          end
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      rem_q   <= ALL_ZERO;
      quo_q   <= ALL_ZERO;
      dvs_q   <= ALL_ZERO;
      cnt_q   <= {CNT_W{1'b0}};
      op_q    <= 2'b00;
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
      done_q  <= 1'b0;
      res_q   <= ALL_ZERO;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      neg_q_q <= neg_q_d;
      neg_r_q <= neg_r_d;
      done_q  <= done_d;
      res_q   <= res_d;
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Directed and randomised checks of div_unit: results, latency, handshake,
// abort and asynchronous reset behaviour.
module tb_div_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  div_unit_if #(.XLEN(32)) bus ();

  div_unit #(.XLEN(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Independent RV32M reference using the simulator's own signed arithmetic.
  function automatic logic [31:0] ref_res(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa, sb;
    sa = a;
    sb = b;
    if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'd0 : a;
    case (op)
      2'b00:   return sa / sb;
      2'b01:   return a / b;
      2'b10:   return sa % sb;
      default: return a % b;
    endcase
  endfunction

  // Issue one op; lat = edges after the accept edge until done is seen
  // (0 = done in the cycle right after accept). rdy = ready right after accept.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat, output logic rdy);
    @(negedge clk);
    bus.start = 1'b1;
    bus.divop = op;
    bus.opr_a = a;
    bus.opr_b = b;
    @(negedge clk);
    bus.start = 1'b0;
    rdy = bus.ready;
    lat = 0;
    while (!bus.done && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    res = bus.opr_res;
  endtask

  initial begin
    logic [31:0] res, last_res, a, b;
    logic [1:0]  op;
    logic        rdy;
    logic        seen;
    int          lat;
    int          exp_lat;

    bus.start = 1'b0;
    bus.divop = 2'b00;
    bus.opr_a = 32'd0;
    bus.opr_b = 32'd0;
    bus.abort = 1'b0;

    #1;
    chk("rst_ready", {31'd0, bus.ready}, 32'd1);
    chk("rst_done", {31'd0, bus.done}, 32'd0);
    chk("rst_res", bus.opr_res, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Unsigned basics and normal latency
    run_op(2'b01, 32'd100, 32'd7, res, lat, rdy);
    chk("divu_100_7", res, 32'd14);
    chk("divu_lat", lat, 32'd33);
    chk("busy_ready", {31'd0, rdy}, 32'd0);
    run_op(2'b11, 32'd100, 32'd7, res, lat, rdy);
    chk("remu_100_7", res, 32'd2);

    // Signed sign handling
    run_op(2'b00, 32'hFFFF_FFF9, 32'd2, res, lat, rdy);
    chk("div_m7_2", res, 32'hFFFF_FFFD);
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, res, lat, rdy);
    chk("rem_m7_2", res, 32'hFFFF_FFFF);
    run_op(2'b10, 32'd7, 32'hFFFF_FFFE, res, lat, rdy);
    chk("rem_7_m2", res, 32'd1);

    // Special cases resolve in one cycle and never drop ready
    run_op(2'b01, 32'd5, 32'd0, res, lat, rdy);
    chk("divu_by0", res, 32'hFFFF_FFFF);
    chk("divu_by0_lat", lat, 32'd0);
    chk("divu_by0_ready", {31'd0, rdy}, 32'd1);
    run_op(2'b10, 32'd5, 32'd0, res, lat, rdy);
    chk("rem_by0", res, 32'd5);
    run_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, res, lat, rdy);
    chk("div_ovf", res, 32'h8000_0000);
    chk("div_ovf_ready", {31'd0, rdy}, 32'd1);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, res, lat, rdy);
    chk("rem_ovf", res, 32'd0);
    chk("rem_ovf_lat", lat, 32'd0);

    // start spam during CALC is ignored; start in the done cycle is accepted
    @(negedge clk);
    bus.start = 1'b1;
    bus.divop = 2'b01;
    bus.opr_a = 32'd100;
    bus.opr_b = 32'd7;
    lat = 0;
    @(negedge clk);
    while (!bus.done && lat < 100) begin
      if (bus.ready) chk("spam_ready", {31'd0, bus.ready}, 32'd0);
      bus.start = 1'b1;
      bus.divop = 2'($urandom_range(0, 3));
      bus.opr_a = $urandom;
      bus.opr_b = $urandom;
      @(negedge clk);
      lat++;
    end
    chk("spam_lat", lat, 32'd33);
    chk("spam_res", bus.opr_res, 32'd14);
    bus.start = 1'b1;
    bus.divop = 2'b01;
    bus.opr_a = 32'd1000;
    bus.opr_b = 32'd10;
    @(negedge clk);
    bus.start = 1'b0;
    lat = 0;
    while (!bus.done && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    chk("b2b_lat", lat, 32'd33);
    chk("b2b_res", bus.opr_res, 32'd100);
    last_res = 32'd100;

    // abort mid-CALC: back to IDLE, no done, result held
    @(negedge clk);
    bus.start = 1'b1;
    bus.divop = 2'b01;
    bus.opr_a = 32'd1000;
    bus.opr_b = 32'd3;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    chk("abort_ready", {31'd0, bus.ready}, 32'd1);
    seen = 1'b0;
    repeat (40) begin
      seen = seen | bus.done;
      @(negedge clk);
    end
    chk("abort_nodone", {31'd0, seen}, 32'd0);
    chk("abort_res", bus.opr_res, last_res);

    // abort beats start in IDLE, even for a one-cycle special case
    bus.start = 1'b1;
    bus.abort = 1'b1;
    bus.divop = 2'b01;
    bus.opr_a = 32'd5;
    bus.opr_b = 32'd0;
    @(negedge clk);
    bus.start = 1'b0;
    bus.abort = 1'b0;
    chk("abort_start_done", {31'd0, bus.done}, 32'd0);
    chk("abort_start_res", bus.opr_res, last_res);
    chk("abort_start_ready", {31'd0, bus.ready}, 32'd1);

    // async reset between edges mid-CALC
    bus.start = 1'b1;
    bus.divop = 2'b01;
    bus.opr_a = 32'hFFFF_FFFF;
    bus.opr_b = 32'd3;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (5) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_done", {31'd0, bus.done}, 32'd0);
    chk("arst_res", bus.opr_res, 32'd0);
    chk("arst_ready", {31'd0, bus.ready}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      seen = seen | bus.done;
      @(negedge clk);
    end
    chk("arst_nodone", {31'd0, seen}, 32'd0);

    // random sweep across all four ops
    for (int i = 0; i < 32; i++) begin
      op = 2'(i % 4);
      a  = $urandom;
      b  = (i % 8 == 7) ? 32'd0 : ($urandom >> $urandom_range(0, 28));
      if (i % 5 == 4) b = twos(b);
      run_op(op, a, b, res, lat, rdy);
      exp_lat = (b == 32'd0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) ? 0 : 33;
      chk($sformatf("sweep%0d_op%0d", i, op), res, ref_res(op, a, b));
      chk($sformatf("sweep%0d_lat", i), lat, exp_lat);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  function automatic logic [31:0] twos(input logic [31:0] v);
    return ~v + 32'd1;
  endfunction

endmodule
